// File: rtl/result_drain_pkg.sv
// Shared definitions for the result-drain slice: datatype encoding, the
// address-generator descriptor, regfile depth and the drain FSM states.
package params;

  localparam int unsigned WORDS = 4;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } datatype_t;

  // Only the datatype field matters to the drain; address fields live with the generator.
  typedef struct packed {
    datatype_t datatype;
  } addrgen_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } drain_state_t;

  function automatic logic [2:0] beat_count(input datatype_t dt, input logic mixed,
                                            input logic [2:0] words);
    return (dt == FP16 && !mixed) ? 3'd2 : words;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Control, lane and downstream-stream signals of the result drain.
interface result_drain_if #(parameter int unsigned NPE = 4);
  import params::*;

  logic              start;
  addrgen_t          addr_type;
  logic              mixed;
  logic              wben;
  logic              out_ready;
  logic [32*NPE-1:0] out_sum;
  logic              m_valid;
  logic              m_ready;
  logic [32*NPE-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, addr_type, mixed, out_sum, m_ready,
    output wben, out_ready, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output start, addr_type, mixed, out_sum, m_ready,
    input  wben, out_ready, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/result_drain_fifo.sv
// Two-entry FIFO buffering lane words between the request side and the
// downstream stream; simultaneous push and pop are both honoured.
module drain_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_ok && count == 2'd2));

endmodule

// File: rtl/result_drain.sv
// Drains WORDS accumulator words from NPE lanes into a valid/ready stream,
// dropping the duplicate packed pairs returned for non-mixed FP16.
module result_drain #(
  parameter int unsigned NPE   = 4,
  parameter int unsigned WORDS = params::WORDS
) (
  input logic            clk,
  input logic            rst,
  result_drain_if.master bus
);
  import params::*;

  localparam int unsigned W       = 32 * NPE;
  localparam logic [2:0]  WORDS_C = 3'(WORDS);

  drain_state_t state, state_nxt;
  datatype_t    dt_q;
  logic         mixed_q;
  logic [2:0]   req_cnt;
  logic [2:0]   rsp_cnt;
  logic [2:0]   beat_cnt;
  logic         inflight;
  logic [1:0]   fifo_count;
  logic [W-1:0] fifo_dout;
  logic [2:0]   occupancy;
  logic         valid_int, pop, push;
  logic         wben_int, out_ready_int, done_int;

  assign valid_int = (fifo_count != 2'd0);
  assign pop       = valid_int && bus.m_ready;
  // Words still in flight in the lanes count against FIFO space.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign push      = inflight && !(dt_q == FP16 && !mixed_q && rsp_cnt >= 3'd2);

  drain_fifo #(.WIDTH(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.out_sum),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt     = state;
    wben_int      = 1'b0;
    out_ready_int = 1'b0;
    done_int      = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_DRAIN;
      S_DRAIN: begin
        wben_int      = 1'b1;
        out_ready_int = (req_cnt < WORDS_C) && (occupancy < 3'd2);
        if (req_cnt == WORDS_C) state_nxt = S_FLUSH;
      end
      S_FLUSH: if (fifo_count == 2'd0 && !inflight) begin
        done_int  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dt_q     <= FP32;
      mixed_q  <= 1'b0;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= out_ready_int;
      if (state == S_IDLE && bus.start) begin
        dt_q     <= bus.addr_type.datatype;
        mixed_q  <= bus.mixed;
        req_cnt  <= '0;
        rsp_cnt  <= '0;
        beat_cnt <= '0;
      end else begin
        if (out_ready_int && req_cnt != WORDS_C) req_cnt  <= req_cnt + 3'd1;
        if (inflight && rsp_cnt != WORDS_C)      rsp_cnt  <= rsp_cnt + 3'd1;
        if (pop && beat_cnt != WORDS_C)          beat_cnt <= beat_cnt + 3'd1;
      end
    end
  end

  // Outputs are forced low while rst is held so the abort is visible at once.
  assign bus.wben      = !rst && wben_int;
  assign bus.out_ready = !rst && out_ready_int;
  assign bus.m_valid   = !rst && valid_int;
  assign bus.m_data    = rst ? '0 : fifo_dout;
  assign bus.m_last    = !rst && valid_int &&
                         (beat_cnt == beat_count(dt_q, mixed_q, WORDS_C) - 3'd1);
  assign bus.busy      = !rst && (state != S_IDLE);
  assign bus.done      = !rst && done_int;

endmodule
